axis_wrr_sched: RTL

Weighted round-robin packet scheduler for the AXI-stream arbitrated multiplexer datapath. It replaces the plain priority/round-robin arbiter when egress bandwidth must be shared by configurable per-port packet quotas. It exposes the same request/acknowledge/grant contract, so the mux's tready/tvalid steering is driven by `grant_encoded` and `grant_valid` unchanged. Grants are packet-granular and are held until the granted port acknowledges its last beat.

---
 rtl/axis_wrr_sched_if.sv | 33 +++
 rtl/axis_wrr_sched.sv | 123 ++++++++++++
 2 files changed

// File: rtl/axis_wrr_sched_if.sv
// Request/acknowledge/grant bundle between an AXI-stream mux
// and its weighted round-robin packet scheduler.
interface axis_wrr_sched_if #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
);
  localparam int CL_PORTS = $clog2(PORTS);

  logic [PORTS-1:0]              request;
  logic [PORTS-1:0]              acknowledge;
  logic [PORTS*WEIGHT_WIDTH-1:0] weight;
  logic [PORTS-1:0]              grant;
  logic                          grant_valid;
  logic [CL_PORTS-1:0]           grant_encoded;

  modport master (
    output request,
    output acknowledge,
    output weight,
    input  grant,
    input  grant_valid,
    input  grant_encoded
  );

  modport slave (
    input  request,
    input  acknowledge,
    input  weight,
    output grant,
    output grant_valid,
    output grant_encoded
  );
endinterface

// File: rtl/axis_wrr_sched.sv
// Weighted round-robin packet scheduler: per-port packet credits,
// refilled from weight when a round is exhausted; grants held to EOP.
module axis_wrr_sched #(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axis_wrr_sched_if.slave       bus
);
  localparam int CL_PORTS = $clog2(PORTS);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                                 state_q, state_d;
  logic [PORTS-1:0][WEIGHT_WIDTH-1:0]     credit_q, credit_d;
  logic [CL_PORTS-1:0]                    ptr_q, ptr_d;
  logic [CL_PORTS-1:0]                    cur_q, cur_d;
  logic [PORTS-1:0]                       grant_q, grant_d;
  logic                                   grant_valid_q, grant_valid_d;
  logic [CL_PORTS-1:0]                    grant_encoded_q, grant_encoded_d;

  logic [PORTS-1:0]    en;
  logic [PORTS-1:0]    elig;
  logic [CL_PORTS-1:0] sel;
  logic [CL_PORTS-1:0] cur_nxt;

  always_comb begin
    en   = '0;
    elig = '0;
    for (int i = 0; i < PORTS; i++) begin
      en[i]   = bus.request[i]
              & (bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
      elig[i] = en[i] & (credit_q[i] != '0);
    end
  end

  // first eligible port at or after ptr, wrapping
  always_comb begin
    logic                found;
    int                  idx;
    logic [CL_PORTS-1:0] idx_w;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx   = (int'(ptr_q) + k) % PORTS;
      idx_w = CL_PORTS'(idx);
      if (!found && elig[idx_w]) begin
        found = 1'b1;
        sel   = idx_w;
      end
    end
  end

  assign cur_nxt = (cur_q == CL_PORTS'(PORTS - 1)) ? '0
                                                   : cur_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    ptr_d           = ptr_q;
    cur_d           = cur_q;
    grant_d         = grant_q;
    grant_valid_d   = grant_valid_q;
    grant_encoded_d = grant_encoded_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (|elig): begin
            grant_d         = {{(PORTS-1){1'b0}}, 1'b1} << sel;
            grant_valid_d   = 1'b1;
            grant_encoded_d = sel;
            credit_d[sel]   = credit_q[sel] - 1'b1;
            cur_d           = sel;
            state_d         = GRANT;
          end
          (~|elig & |en): begin
            for (int i = 0; i < PORTS; i++)
              credit_d[i] = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
          end
          default: ;
        endcase
      end
      GRANT: begin
        if (bus.acknowledge[cur_q]) begin
          grant_d         = '0;
          grant_valid_d   = 1'b0;
          grant_encoded_d = '0;
          state_d         = IDLE;
          // stay on this port while it still has credit this round
          ptr_d = (credit_q[cur_q] == '0) ? cur_nxt : cur_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      ptr_q           <= '0;
      cur_q           <= '0;
      grant_q         <= '0;
      grant_valid_q   <= 1'b0;
      grant_encoded_q <= '0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      ptr_q           <= ptr_d;
      cur_q           <= cur_d;
      grant_q         <= grant_d;
      grant_valid_q   <= grant_valid_d;
      grant_encoded_q <= grant_encoded_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_encoded = grant_encoded_q;
endmodule
